mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
// - Bus-side responder for the memory manager's request protocol: accepts single read/write requests, holds bus_full while servicing, returns read data.
// - Backs requests with an on-chip word array and a programmable service latency.
// - Sits between mem_manager (address_out/data_out_BUS/memRead/memWrite) and the data/instruction store; drives data_in_BUS and bus_full back.
// PARAMETERS
// - DEPTH_WORDS  256  number of 32-bit words in the array (power of 2, >=4)
// - LATENCY      2    cycles from accept edge to response cycle (>=1)
// PORTS
// - clk          in   1   single clock, rising edge
// - rst          in   1   asynchronous, active-low reset
// - address_in   in   32  byte address of request
// - data_in      in   32  write data (from manager data_out_BUS)
// - memRead      in   1   read request level
// - memWrite     in   1   write request level
// - data_out     out  32  read data (to manager data_in_BUS)
// - bus_full     out  1   responder busy; new requests ignored while high
// - rd_valid     out  1   one-cycle pulse: data_out holds fresh read data
// - wr_done      out  1   one-cycle pulse: write committed
// - addr_err     out  1   one-cycle pulse with response: misaligned or out-of-range address
// BEHAVIOUR
// - Reset (rst low, async): state=IDLE, data_out=0, bus_full=0, rd_valid=0, wr_done=0, addr_err=0, counter=0; array contents NOT cleared.
// - States: IDLE -> BUSY -> RESP -> IDLE.
// - IDLE: on edge with (memRead|memWrite): latch address, data, op; go BUSY; counter=LATENCY-1. memRead wins if both high.
// - BUSY: bus_full=1; decrement counter each edge; counter==0 -> RESP (LATENCY=1 => BUSY lasts one cycle).
// - RESP: bus_full=1; exactly one of rd_valid/wr_done pulses; addr_err may pulse alongside; next edge -> IDLE, bus_full=0.
// - Total: accept at edge k; response cycle follows edge k+LATENCY; bus_full high for LATENCY+1 cycles.
// - Index = address[log2(DEPTH_WORDS)+1:2]. Error if address[1:0]!=0 or any address bit above index range set.
// - Error read: data_out=32'hDEAD_BEEF, rd_valid=1, addr_err=1. Error write: array unchanged, wr_done=1, addr_err=1.
// - Read: data_out updated on entry to RESP; holds until next read response or reset.
// - Write: array written on the edge entering RESP.
// - Requests present in BUSY/RESP ignored (not queued); a level still high in IDLE is accepted as a new request.
// - Reset mid-BUSY: transaction aborted, pending write dropped, no pulses.
// STRUCTURE
// - Package mem_bus_pkg: resp_state_t {IDLE,BUSY,RESP}; localparam ERR_DATA=32'hDEAD_BEEF.
// - Sub-module mem_word_array (DEPTH_WORDS x 32, sync write, sync read with enable); FSM, counter, address checking in top.
// TESTING
// - Reset: rst low mid-stream -> all outputs 0 immediately; after release bus_full=0, state IDLE.
// - Write 0x0000_0010 <= 0xCAFE_F00D, LATENCY=2 -> bus_full high 3 cycles, wr_done 1 pulse; read 0x10 -> data_out=0xCAFE_F00D, rd_valid 1 pulse.
// - memRead & memWrite same cycle at 0x20 -> read performed, array at 0x20 unchanged.
// - Misaligned 0x0000_0013 read -> data_out=0xDEAD_BEEF, rd_valid=1, addr_err=1; out-of-range write 0x0000_0400 (DEPTH 256) -> addr_err=1, no array change.
// - New memWrite pulse while bus_full=1 -> ignored, no extra wr_done.
// - rst low during BUSY of write 0x8 <= 0x1234 -> no wr_done; later read 0x8 returns prior contents.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared types and constants for the memory bus responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} resp_state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // Word-aligned and inside the 2^idx_w word window, or it is an error.
  function automatic logic addr_bad(input logic [31:0] a, input int idx_w);
    return (a[1:0] != 2'b00) || ((a >> (idx_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/response wires between mem_manager (master) and the responder (slave).
interface mem_bus_responder_if;
  import mem_bus_pkg::*;

  logic [31:0] address_in;
  logic [31:0] data_in;
  logic        memRead;
  logic        memWrite;
  logic [31:0] data_out;
  logic        bus_full;
  logic        rd_valid;
  logic        wr_done;
  logic        addr_err;

  modport master (
    output address_in, data_in, memRead, memWrite,
    input  data_out, bus_full, rd_valid, wr_done, addr_err
  );

  modport slave (
    input  address_in, data_in, memRead, memWrite,
    output data_out, bus_full, rd_valid, wr_done, addr_err
  );
endinterface

// File: rtl/mem_bus_responder_array.sv
// DEPTH_WORDS x 32 word store: sync write, sync read with enable; contents survive reset.
module mem_word_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the read register resets, so data_out reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_bus_responder.sv
// Single-outstanding memory responder: accept, hold bus_full for LATENCY+1 cycles, respond.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic                clk,
  input logic                rst,
  mem_bus_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  resp_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             op_rd_q, err_q, rd_err_q;
  logic             bus_full_q, rd_valid_q, wr_done_q, addr_err_q;
  logic [31:0]      arr_rdata;
  logic             req, fire;

  assign req  = bus.memRead | bus.memWrite;
  assign fire = (state == BUSY) && (cnt == '0);

  // Array access happens on the edge entering RESP; erroneous requests never touch it.
  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_arr (
    .clk   (clk),
    .rst   (rst),
    .we    (fire & ~op_rd_q & ~err_q),
    .re    (fire &  op_rd_q & ~err_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      op_rd_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_err_q   <= 1'b0;
      bus_full_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          idx_q      <= bus.address_in[IDX_W+1:2];
          wdata_q    <= bus.data_in;
          op_rd_q    <= bus.memRead;
          err_q      <= addr_bad(bus.address_in, IDX_W);
          cnt        <= CNT_W'(LATENCY - 1);
          bus_full_q <= 1'b1;
          state      <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          rd_valid_q <= op_rd_q;
          wr_done_q  <= ~op_rd_q;
          addr_err_q <= err_q;
          if (op_rd_q) rd_err_q <= err_q;
          state      <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: begin
          rd_valid_q <= 1'b0;
          wr_done_q  <= 1'b0;
          addr_err_q <= 1'b0;
          bus_full_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Last read outcome selects between the array's held word and the error pattern.
  assign bus.data_out = rd_err_q ? ERR_DATA : arr_rdata;
  assign bus.bus_full = bus_full_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_done  = wr_done_q;
  assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Random and directed transactions against a word-array reference model.
module tb_mem_bus_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_responder_if bif();

  mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  task automatic idle_inputs();
    bif.address_in = '0;
    bif.data_in    = '0;
    bif.memRead    = 1'b0;
    bif.memWrite   = 1'b0;
  endtask

  // One request; inject drives a stray write while the responder is busy.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input bit inject);
    int busy_n = 0, rv_n = 0, wd_n = 0, ae_n = 0, cyc = 0;
    logic [31:0] rdat = '0, exp_d;
    bit bad = is_bad(a);
    @(negedge clk);
    bif.address_in = a; bif.data_in = d; bif.memRead = rd; bif.memWrite = wr;
    @(negedge clk);
    idle_inputs();
    if (inject) begin
      bif.memWrite = 1'b1; bif.address_in = a ^ 32'h4; bif.data_in = ~d;
    end
    while (bif.bus_full && cyc < 20) begin
      busy_n++;
      if (bif.rd_valid) begin rv_n++; rdat = bif.data_out; end
      if (bif.wr_done)  wd_n++;
      if (bif.addr_err) ae_n++;
      @(negedge clk);
      cyc++;
      idle_inputs();
    end
    chk("no_timeout", 32'(cyc < 20), 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'(LAT + 1));
    chk("rd_valid_pulses", 32'(rv_n), rd ? 32'd1 : 32'd0);
    chk("wr_done_pulses", 32'(wd_n), rd ? 32'd0 : 32'd1);
    chk("addr_err_pulses", 32'(ae_n), bad ? 32'd1 : 32'd0);
    if (rd) begin
      exp_d = bad ? 32'hDEAD_BEEF : ref_mem[a / 4];
      chk("rd_data", rdat, exp_d);
      last_rd = exp_d;
    end else if (!bad) begin
      ref_mem[a / 4] = d;
    end
    chk("data_hold", bif.data_out, last_rd);
    @(negedge clk);
    chk("idle_after", {bif.bus_full, bif.rd_valid, bif.wr_done, bif.addr_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    bit r, w;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_outs", {bif.bus_full, bif.rd_valid, bif.wr_done, bif.addr_err}, 32'd0);
    chk("reset_data", bif.data_out, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    txn(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("cafe_model", last_rd, 32'hCAFE_F00D);
    txn(1'b1, 1'b1, 32'h20, 32'h5555_AAAA, 1'b0);
    txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    txn(1'b0, 1'b1, 32'h400, 32'h7777_7777, 1'b0);
    txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    txn(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, 1'b1);
    txn(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);

    // Reset while a write to 0x8 is still in BUSY.
    @(negedge clk);
    bif.address_in = 32'h8; bif.data_in = 32'h1234; bif.memWrite = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("pre_reset_busy", 32'(bif.bus_full), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outs", {bif.bus_full, bif.rd_valid, bif.wr_done, bif.addr_err}, 32'd0);
    chk("midrst_data", bif.data_out, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {bif.bus_full, bif.wr_done}, 32'd0);
    end
    txn(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 8)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (kind == 8) a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
      else                a = $urandom | 32'h0000_0400;
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(r, w, a, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
